// File: rtl/controlador_buffer_rolhas_param_pkg.sv
// Shared types and helpers for the two-level cork buffer controller:
// FSM state encoding, count-width helpers and the parameter sanity check.
package pkg_rolhas;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic int calc_rw(input int res_max);
        return $clog2(res_max + 1);
    endfunction

    function automatic int calc_fw(input int feed_max);
        return $clog2(feed_max + 1);
    endfunction

    // A batch must fit in the feeder on top of the low threshold, or the feeder could overflow.
    function automatic bit params_ok(input int res_max, input int res_init,
                                     input int feed_max, input int feed_min,
                                     input int xfer_qty);
        return (xfer_qty > 0) && (feed_min >= 0) &&
               (feed_min + xfer_qty <= feed_max) && (res_init <= res_max);
    endfunction

endpackage

// File: rtl/controlador_buffer_rolhas_param_contador.sv
// Width-parametrised up/down counter with synchronous load and saturation at 0 and MAX.
// Simultaneous up and down cancel out and leave the count unchanged.
module contador_updown_sat #(
    parameter int W    = 8,
    parameter int MAX  = 255,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_up,
    input  logic         i_down,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= W'(INIT);
        end else if (i_load) begin
            r_count <= (i_load_val > W'(MAX)) ? W'(MAX) : i_load_val;
        end else if (i_up && !i_down) begin
            if (r_count != W'(MAX)) r_count <= r_count + W'(1);
        end else if (i_down && !i_up) begin
            if (r_count != '0) r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/controlador_buffer_rolhas_param.sv
// Two-level cork stock controller: operator-loaded reservoir feeding the sealing-station
// feeder in fixed batches whenever the feeder runs low.
module controlador_buffer_rolhas_param
    import pkg_rolhas::*;
#(
    parameter int  RES_MAX  = 99,
    parameter int  RES_INIT = 20,
    parameter int  FEED_MAX = 31,
    parameter int  FEED_MIN = 5,
    parameter int  XFER_QTY = 20,
    parameter int  QTY_W    = 7,
    localparam int RW       = calc_rw(RES_MAX),
    localparam int FW       = calc_fw(FEED_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_load_valid,
    input  logic [QTY_W-1:0] op_load_qty,
    output logic             op_load_accept,
    output logic             op_load_reject,
    input  logic             consume,
    output logic             consume_err,
    output logic [RW-1:0]    res_count,
    output logic [FW-1:0]    feed_count,
    output logic             feeder_empty,
    output logic             feeder_low,
    output logic             res_low,
    output logic             xfer_busy,
    output logic [1:0]       state
);

    localparam int SUM_W     = ((RW > QTY_W) ? RW : QTY_W) + 1;
    localparam int BW        = $clog2(XFER_QTY + 1);
    localparam bit PARAMS_OK = params_ok(RES_MAX, RES_INIT, FEED_MAX, FEED_MIN, XFER_QTY);

    state_t           r_state;
    state_t           w_next_state;
    logic [BW-1:0]    r_batch;
    logic             r_accept;
    logic             r_reject;
    logic             r_consume_err;
    logic             w_move;
    logic             w_in_load;
    logic             w_load_ok;
    logic             w_xfer_go;
    logic [SUM_W-1:0] w_sum;

    assign w_move    = (r_state == XFER);
    assign w_in_load = (r_state == LOAD);

    // One extra bit on the sum so an oversized load is rejected instead of wrapping.
    assign w_sum     = SUM_W'(res_count) + SUM_W'(op_load_qty);
    assign w_load_ok = (op_load_qty != '0) && (w_sum <= SUM_W'(RES_MAX));

    assign feeder_empty = (feed_count == '0);
    assign feeder_low   = (feed_count <= FW'(FEED_MIN));
    assign res_low      = (res_count < RW'(XFER_QTY));
    assign w_xfer_go    = feeder_low && !res_low;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer_go)          w_next_state = XFER;
                else if (op_load_valid) w_next_state = LOAD;
            end
            XFER: begin
                if (r_batch == BW'(XFER_QTY - 1)) w_next_state = IDLE;
            end
            LOAD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Batch counter is held clear outside XFER so each batch starts from zero.
    always_ff @(posedge clk) begin
        if (rst)                  r_batch <= '0;
        else if (r_state == IDLE) r_batch <= '0;
        else if (w_move)          r_batch <= r_batch + BW'(1);
    end

    // A consume that coincides with a transfer move is covered by the incoming cork.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_accept      <= 1'b0;
            r_reject      <= 1'b0;
            r_consume_err <= 1'b0;
        end else begin
            r_accept      <= w_in_load && w_load_ok;
            r_reject      <= w_in_load && !w_load_ok;
            r_consume_err <= consume && feeder_empty && !w_move;
        end
    end

    contador_updown_sat #(
        .W    (RW),
        .MAX  (RES_MAX),
        .INIT (RES_INIT)
    ) u_res (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_in_load && w_load_ok),
        .i_load_val (w_sum[RW-1:0]),
        .i_up       (1'b0),
        .i_down     (w_move),
        .o_count    (res_count)
    );

    contador_updown_sat #(
        .W    (FW),
        .MAX  (FEED_MAX),
        .INIT (0)
    ) u_feed (
        .clk        (clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_up       (w_move),
        .i_down     (consume),
        .o_count    (feed_count)
    );

    assign op_load_accept = r_accept;
    assign op_load_reject = r_reject;
    assign consume_err    = r_consume_err;
    assign xfer_busy      = w_move;
    assign state          = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (PARAMS_OK);
            assert (int'(feed_count) <= FEED_MAX);
            assert (int'(res_count) <= RES_MAX);
        end
    end

endmodule

// File: tb/tb_controlador_buffer_rolhas_param.sv
// Self-checking bench: a transaction-level stock model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_controlador_buffer_rolhas_param;

    localparam int RES_MAX  = 99;
    localparam int RES_INIT = 20;
    localparam int FEED_MAX = 31;
    localparam int FEED_MIN = 5;
    localparam int XFER_QTY = 20;
    localparam int QTY_W    = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_load_valid = 1'b0;
    logic [QTY_W-1:0] op_load_qty = '0;
    logic             op_load_accept;
    logic             op_load_reject;
    logic             consume = 1'b0;
    logic             consume_err;
    logic [6:0]       res_count;
    logic [4:0]       feed_count;
    logic             feeder_empty;
    logic             feeder_low;
    logic             res_low;
    logic             xfer_busy;
    logic [1:0]       state;

    int n_run  = 0;
    int n_fail = 0;

    controlador_buffer_rolhas_param #(
        .RES_MAX  (RES_MAX),
        .RES_INIT (RES_INIT),
        .FEED_MAX (FEED_MAX),
        .FEED_MIN (FEED_MIN),
        .XFER_QTY (XFER_QTY),
        .QTY_W    (QTY_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_load_valid  (op_load_valid),
        .op_load_qty    (op_load_qty),
        .op_load_accept (op_load_accept),
        .op_load_reject (op_load_reject),
        .consume        (consume),
        .consume_err    (consume_err),
        .res_count      (res_count),
        .feed_count     (feed_count),
        .feeder_empty   (feeder_empty),
        .feeder_low     (feeder_low),
        .res_low        (res_low),
        .xfer_busy      (xfer_busy),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stock model: corks in reservoir and feeder, moves still owed in the current
    // batch, and whether an operator request is being answered this cycle.
    int m_res, m_feed, m_left, m_nr, m_nf, m_sum;
    bit m_ld, m_acc, m_rej, m_err, m_moving;
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_res = RES_INIT; m_feed = 0; m_left = 0; m_ld = 0;
            m_acc = 0; m_rej = 0; m_err = 0; m_ready = 1;
        end else if (m_ready) begin
            m_moving = (m_left > 0);
            m_nr = m_res; m_nf = m_feed;
            m_acc = 0; m_rej = 0; m_err = 0;
            if (m_moving) begin
                m_nr = m_nr - 1; m_nf = m_nf + 1; m_left = m_left - 1;
            end
            if (consume) begin
                if (m_nf > 0) m_nf = m_nf - 1;
                else          m_err = 1;
            end
            if (m_ld) begin
                m_ld  = 0;
                m_sum = m_res + int'(op_load_qty);
                if (op_load_qty == 0 || m_sum > RES_MAX) m_rej = 1;
                else begin m_nr = m_sum; m_acc = 1; end
            end else if (!m_moving) begin
                if (m_feed <= FEED_MIN && m_res >= XFER_QTY) m_left = XFER_QTY;
                else if (op_load_valid)                      m_ld = 1;
            end
            m_res = m_nr; m_feed = m_nf;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("res_count",      res_count,      m_res);
            check("feed_count",     feed_count,     m_feed);
            check("feeder_empty",   feeder_empty,   m_feed == 0);
            check("feeder_low",     feeder_low,     m_feed <= FEED_MIN);
            check("res_low",        res_low,        m_res < XFER_QTY);
            check("xfer_busy",      xfer_busy,      m_left > 0);
            check("state",          state,          (m_left > 0) ? 1 : (m_ld ? 2 : 0));
            check("op_load_accept", op_load_accept, m_acc);
            check("op_load_reject", op_load_reject, m_rej);
            check("consume_err",    consume_err,    m_err);
        end
    end

    task automatic consume_n(input int n);
        for (int i = 0; i < n; i++) begin
            consume = 1'b1;
            @(negedge clk);
        end
        consume = 1'b0;
    endtask

    task automatic do_load(input int qty, output bit acc, output bit rej, output int lat);
        op_load_qty   = QTY_W'(qty);
        op_load_valid = 1'b1;
        acc = 0; rej = 0; lat = 0;
        while (!(acc || rej) && lat < 40) begin
            @(negedge clk);
            lat++;
            acc = op_load_accept;
            rej = op_load_reject;
        end
        op_load_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, rej;
        int lat;

        // Reset release, then the automatic first batch.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst res", res_count, 20);
        check("rst feed", feed_count, 0);
        check("rst state", state, 0);
        @(negedge clk);
        check("first xfer state", state, 1);
        repeat (20) @(negedge clk);
        check("batch1 feed", feed_count, 20);
        check("batch1 res", res_count, 0);
        check("batch1 state", state, 0);
        check("batch1 res_low", res_low, 1);

        // Operator loads: accept, overflow reject, zero reject.
        do_load(60, acc, rej, lat);
        check("load60 latency", lat, 2);
        check("load60 accept", acc, 1);
        check("load60 res", res_count, 60);
        @(negedge clk);
        do_load(40, acc, rej, lat);
        check("load40 reject", rej, 1);
        check("load40 res", res_count, 60);
        @(negedge clk);
        do_load(0, acc, rej, lat);
        check("load0 reject", rej, 1);
        @(negedge clk);

        // Drain to the low threshold; the transfer starts and refills.
        consume_n(16);
        check("drain feed", feed_count, 4);
        check("drain feeder_low", feeder_low, 1);
        check("drain state", state, 1);
        repeat (20) @(negedge clk);
        check("batch2 feed", feed_count, 24);
        check("batch2 res", res_count, 40);
        check("batch2 state", state, 0);

        // Consume on every move: feeder holds steady while the reservoir drains.
        consume_n(19);
        @(negedge clk);
        consume_n(20);
        check("hold feed", feed_count, 5);
        check("hold res", res_count, 20);
        repeat (22) @(negedge clk);
        check("batch4 feed", feed_count, 25);
        check("batch4 res", res_count, 0);

        // Empty feeder with a short reservoir: error pulse, no transfer.
        do_load(10, acc, rej, lat);
        check("load10 accept", acc, 1);
        consume_n(25);
        consume_n(1);
        check("underflow err", consume_err, 1);
        check("underflow feed", feed_count, 0);
        check("underflow empty", feeder_empty, 1);
        check("underflow state", state, 0);
        check("underflow res", res_count, 10);

        // Transfer beats a pending load; consume on an empty feeder during a move.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op_load_qty   = QTY_W'(5);
        op_load_valid = 1'b1;
        @(negedge clk);
        check("prio state", state, 1);
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
        check("empty move feed", feed_count, 0);
        check("empty move err", consume_err, 0);
        check("empty move res", res_count, 19);
        lat = 2; acc = 0; rej = 0;
        while (!(acc || rej) && lat < 40) begin
            @(negedge clk);
            lat++;
            acc = op_load_accept;
            rej = op_load_reject;
        end
        op_load_valid = 1'b0;
        check("deferred latency", lat, 23);
        check("deferred accept", acc, 1);
        check("deferred res", res_count, 5);
        check("deferred feed", feed_count, 19);

        // Reset in the middle of a batch.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (7) @(negedge clk);
        check("mid res", res_count, 13);
        check("mid feed", feed_count, 7);
        check("mid state", state, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort state", state, 0);
        check("abort res", res_count, 20);
        check("abort feed", feed_count, 0);
        check("abort busy", xfer_busy, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_buffer_rolhas_param.md
Name: controlador_buffer_rolhas_param

Overview:
Parametrised two-level cork stock controller for the filling/sealing line. It manages a secondary reservoir loaded by the operator and a primary feeder drained by the sealing station. It transfers fixed-size batches automatically from the reservoir to the feeder whenever the feeder runs low. It replaces the fixed-width buffer counters and the transfer/operator control FSM pair with a single configurable block, adding load rejection, an underflow flag and correct handling of simultaneous events.

Parameters:
RES_MAX, 99, reservoir capacity in corks (operator loads must not exceed this)
RES_INIT, 20, reservoir content after reset
FEED_MAX, 31, feeder capacity
FEED_MIN, 5, feeder low threshold; transfer is requested when feeder <= FEED_MIN
XFER_QTY, 20, corks moved per transfer batch; constraint FEED_MIN + XFER_QTY <= FEED_MAX, RES_INIT <= RES_MAX
QTY_W, 7, width of the operator load quantity

Ports:
clk  in  1  system clock (divided clock domain)
rst  in  1  synchronous, active-high reset
op_load_valid  in  1  operator load request (level); held until accept or reject
op_load_qty  in  QTY_W  corks to add; sampled while op_load_valid=1
op_load_accept  out  1  one-cycle pulse: load applied
op_load_reject  out  1  one-cycle pulse: load refused (overflow or qty=0)
consume  in  1  one-cycle pulse from the sealing FSM: one cork used
consume_err  out  1  one-cycle pulse: consume arrived with feeder=0
res_count  out  RW=$clog2(RES_MAX+1)  reservoir content
feed_count  out  FW=$clog2(FEED_MAX+1)  feeder content
feeder_empty  out  1  feed_count==0 (drives the sealing FSM "ro" input)
feeder_low  out  1  feed_count<=FEED_MIN
res_low  out  1  res_count<XFER_QTY (operator alarm)
xfer_busy  out  1  high while in state XFER
state  out  2  FSM state for debug/display

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE, res_count=RES_INIT, feed_count=0, all pulse outputs=0, batch counter=0. rst mid-transfer aborts the batch. Already-moved corks are not restored, because the counts are reinitialised.
- FSM states: IDLE=0, XFER=1, LOAD=2.
- IDLE:
  - if feeder_low and !res_low, go to XFER and clear the batch counter. Transfer has priority over a pending load.
  - else if op_load_valid, go to LOAD.
- XFER: each cycle res_count-=1, feed_count+=1, batch counter+=1. After the XFER_QTY-th move, return to IDLE. The batch is always completed, except on rst. Total duration is XFER_QTY cycles.
- LOAD: single cycle, then IDLE.
  - If op_load_qty==0 or res_count+op_load_qty > RES_MAX: op_load_reject=1 and res_count is unchanged.
  - Otherwise res_count+=op_load_qty and op_load_accept=1.
  - The sum is computed at RW+1 bits, so there is no wrap.
  - The response pulse arrives 2 cycles after op_load_valid is seen in IDLE. The operator drops valid on the response; valid still high on the cycle after the response is treated as a new request.
- consume (any state, including LOAD and XFER):
  - feed_count>0: decrement.
  - feed_count==0: no change and consume_err=1 in the next cycle. No wrap to max.
- Simultaneous consume and XFER move in one cycle: feed_count is unchanged (net +1-1) and res_count still decrements.
- Simultaneous consume and XFER move with feed_count==0: the transfer increment applies, the consume is honoured (net 0), and there is no consume_err.
- Flags feeder_empty, feeder_low and res_low are combinational from the registered counts. The count and flag update latency is 1 cycle.
- Counters never exceed their max by construction (parameter constraint). An assertion fires if feed_count>FEED_MAX or res_count>RES_MAX.

Decomposition:
- Package pkg_rolhas: state enum (IDLE/XFER/LOAD), width functions RW/FW via $clog2, parameter-check macro.
- One natural sub-module: contador_updown_sat. It is a width-parametrised up/down counter with sync load and saturation at 0/MAX, instantiated twice (reservoir and feeder).
- The FSM and batch counter stay in the top.

Test Plan:
- Reset release: res=20, feed=0. Next cycle state=XFER. After 20 cycles feed=20, res=0, state=IDLE, res_low=1.
- Load from res=0, qty=60 -> accept pulse, res=60. Then qty=40 -> reject pulse, res stays 60. qty=0 -> reject.
- Feed=6, res=60, 2 consume pulses -> feed=4, feeder_low=1. XFER starts, 20 cycles, final feed=24, res=40.
- Consume every cycle during XFER from feed=5 -> feed held at 5 throughout; res decrements 20 -> 40 to 20 (from 40).
- Feed=0, res=10 (<XFER_QTY), consume -> consume_err pulse, feed stays 0, no XFER, feeder_empty=1.
- rst asserted on cycle 7 of a batch -> next cycle state=IDLE, res=RES_INIT, feed=0; a pending load arriving with the transfer condition true waits until after the batch.
